nibble_alu_seq: RTL and testbench
=================================

NIBBLE_ALU_SEQ -- requirements
Module: nibble_alu_seq

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset; ports are named clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on the clk rising edge.
REQ-004 in_valid  input  1  a request is present on in_op/in_a/in_b.
REQ-005 in_ready  output  1  the block can accept a request.
REQ-006 in_op  input  2  operation code: 00 AND, 01 OR, 10 XOR, 11 ADD.
REQ-007 in_a  input  16  operand A.
REQ-008 in_b  input  16  operand B.
REQ-009 out_valid  output  1  the result on out_data/out_carry is valid.
REQ-010 out_ready  input  1  the consumer accepts the result.
REQ-011 out_data  output  16  result word.
REQ-012 out_carry  output  1  carry-out of nibble 3 for ADD; 0 for the logic ops.
REQ-013 busy  output  1  the FSM is not in IDLE.

Function
REQ-014 The block SHALL compute one 16-bit operation by time-sharing a single 4-bit slice over nibbles 0..3, least-significant nibble first.
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-016 In IDLE, in_ready=1.
  - On an edge with in_valid=1, the block latches in_op, in_a and in_b.
  - It clears nibble_idx and carry, and goes to RUN.
REQ-017 In RUN, each edge SHALL do all of the following:
  - compute slice(a[idx], b[idx], op, carry);
  - write the 4-bit result into result[idx];
  - update carry (ADD only; forced 0 for the logic ops);
  - increment idx.
REQ-018 After the RUN edge with idx=3, the FSM SHALL go to DONE.
REQ-019 In DONE, out_valid=1; on an edge with out_ready=1, the FSM SHALL return to IDLE.
REQ-020 Latency SHALL be 4 cycles: out_valid rises in the cycle after the 4th RUN edge, counted from the accept edge.
  - Minimum spacing between accepts is 6 cycles.
REQ-021 in_ready SHALL be 0 in RUN and DONE.
  - in_valid in those states is ignored and does not corrupt the latched operands.
REQ-022 Changes on in_a, in_b and in_op after the accept edge SHALL NOT affect the result.
REQ-023 While out_ready=0 in DONE, out_valid, out_data and out_carry SHALL hold stable indefinitely.
REQ-024 ADD SHALL wrap modulo 2^16 and report the carry-out in out_carry.
  - Example: 0xFFFF+0x0001 gives 0x0000 with carry 1.
REQ-025 out_data and out_carry SHALL retain the last result after the handoff, until the next DONE.
REQ-026 busy SHALL equal (state != IDLE).

Reset
REQ-027 On a reset edge, the FSM SHALL enter IDLE from any state, including mid-RUN and DONE.
REQ-028 On reset, the outputs SHALL take these values:
  - in_ready=1;
  - out_valid=0;
  - out_data=0x0000;
  - out_carry=0;
  - busy=0.
REQ-029 On reset, the internal registers SHALL clear: carry=0, nibble_idx=0, operand and result registers=0.
REQ-030 A request aborted by reset SHALL be discarded and SHALL produce no out_valid.

Structure
REQ-031 Package nibble_alu_pkg SHALL hold the op-code constants (OP_AND, OP_OR, OP_XOR, OP_ADD), the state encoding and NIBBLES=4.
REQ-032 The block SHALL instantiate exactly one combinational sub-module, logic4_slice.
  - Inputs: a[3:0], b[3:0], op[1:0], cin.
  - Outputs: y[3:0], cout.
REQ-033 All sequencing SHALL reside in nibble_alu_seq, and the slice SHALL hold no state.

Verification
REQ-034 AND: a=0xF0F0, b=0xFF00 -> out_data=0xF000, out_carry=0, out_valid rises 4 cycles after the accept.
REQ-035 ADD with carry chain: a=0x0FFF, b=0x0001 -> 0x1000, carry 0; a=0xFFFF, b=0x0001 -> 0x0000, carry 1.
REQ-036 Backpressure: out_ready=0 for 10 cycles in DONE -> outputs stable and in_ready=0 throughout; one out_ready pulse -> IDLE on the next cycle.
REQ-037 Busy rejection: in_valid=1 with new operands during RUN -> ignored; the first request's result is unchanged; the second is accepted only once in_ready=1.
REQ-038 Reset at the 2nd RUN edge -> next cycle in_ready=1, busy=0, out_valid=0, out_data=0x0000; a following XOR a=0xAAAA, b=0xFFFF -> 0x5555.
REQ-039 Random sweep: 256 random (op, a, b) requests with random out_ready -> every result matches a reference model.

Source files
------------

// File: rtl/nibble_alu_pkg.sv
// nibble_alu_pkg
//   Shared definitions for the nibble-serial ALU: op-code constants,
//   FSM state encoding, nibble geometry and a small op decode helper.
package nibble_alu_pkg;

  localparam int NIBBLES = 4;
  localparam int NIB_W   = 4;
  localparam int WORD_W  = NIBBLES * NIB_W;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Only ADD propagates a carry between nibbles.
  function automatic logic op_uses_carry(input logic [1:0] op);
    return (op == OP_ADD);
  endfunction

endpackage

// File: rtl/logic4_slice.sv
// logic4_slice
//   Purely combinational 4-bit ALU slice, time-shared by nibble_alu_seq.
//   Ports:
//     a, b  [3:0]  operand nibbles
//     op    [1:0]  operation (OP_AND / OP_OR / OP_XOR / OP_ADD)
//     cin          carry-in (only meaningful for ADD)
//     y     [3:0]  result nibble
//     cout         carry-out for ADD, 0 for the logic operations
module logic4_slice
  import nibble_alu_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [1:0] op,
  input  logic       cin,
  output logic [3:0] y,
  output logic       cout
);

  logic [4:0] sum;

  assign sum = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

  always_comb begin
    y    = 4'h0;
    cout = 1'b0;
    case (op)
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_ADD: begin
        y    = sum[3:0];
        cout = op_uses_carry(op) & sum[4];
      end
      default: begin
        y    = 4'h0;
        cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/nibble_alu_seq.sv
// nibble_alu_seq
//   16-bit AND/OR/XOR/ADD unit that processes one nibble per clock through
//   a single logic4_slice, least-significant nibble first.
//   Ports:
//     clk, rst_n         clock, synchronous active-low reset
//     in_valid/in_ready  request handshake (in_op, in_a, in_b)
//     out_valid/out_ready result handshake (out_data, out_carry)
//     busy               FSM is not idle
//   Flow: IDLE --accept--> RUN (4 edges, one per nibble) --> DONE --out_ready--> IDLE
module nibble_alu_seq
  import nibble_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_carry,
  output logic        busy
);

  state_t state_reg, state_next;

  logic [1:0]        op_reg;
  logic [WORD_W-1:0] a_reg;
  logic [WORD_W-1:0] b_reg;
  logic [1:0]        idx_reg;
  logic              carry_reg;
  logic [NIB_W-1:0]  res_nib_reg [NIBBLES];
  logic [WORD_W-1:0] out_data_reg;
  logic              out_carry_reg;

  logic              accept;
  logic              run_step;
  logic              last_step;
  logic [NIB_W-1:0]  slice_a;
  logic [NIB_W-1:0]  slice_b;
  logic [NIB_W-1:0]  slice_y;
  logic              slice_cout;
  logic [WORD_W-1:0] final_word;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (in_valid)  state_next = ST_RUN;
      ST_RUN:  if (last_step) state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  assign busy      = (state_reg != ST_IDLE);

  assign accept    = in_ready & in_valid;
  assign run_step  = (state_reg == ST_RUN);
  assign last_step = run_step & (idx_reg == 2'(NIBBLES - 1));

  // ---------------- slice ----------------
  assign slice_a = a_reg[{idx_reg, 2'b00} +: NIB_W];
  assign slice_b = b_reg[{idx_reg, 2'b00} +: NIB_W];

  logic4_slice u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .op   (op_reg),
    .cin  (carry_reg),
    .y    (slice_y),
    .cout (slice_cout)
  );

  // ---------------- operand / sequencing registers ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_reg    <= OP_AND;
      a_reg     <= '0;
      b_reg     <= '0;
      idx_reg   <= 2'd0;
      carry_reg <= 1'b0;
    end else if (accept) begin
      op_reg    <= in_op;
      a_reg     <= in_a;
      b_reg     <= in_b;
      idx_reg   <= 2'd0;
      carry_reg <= 1'b0;
    end else if (run_step) begin
      idx_reg   <= idx_reg + 2'd1;
      carry_reg <= slice_cout;
    end
  end

  // ---------------- per-nibble result registers ----------------
  // On the last step the top nibble is still on the slice output, so the
  // completed word is assembled from the stored nibbles plus slice_y.
  generate
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
      always_ff @(posedge clk) begin
        if (!rst_n)
          res_nib_reg[gi] <= '0;
        else if (run_step && idx_reg == 2'(gi))
          res_nib_reg[gi] <= slice_y;
      end

      if (gi == NIBBLES - 1) begin : g_top
        assign final_word[gi*NIB_W +: NIB_W] = slice_y;
      end else begin : g_low
        assign final_word[gi*NIB_W +: NIB_W] = res_nib_reg[gi];
      end
    end
  endgenerate

  // Output registers load only on completion so the previous result stays
  // visible while the next request is being computed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_reg  <= '0;
      out_carry_reg <= 1'b0;
    end else if (last_step) begin
      out_data_reg  <= final_word;
      out_carry_reg <= slice_cout;
    end
  end

  assign out_data  = out_data_reg;
  assign out_carry = out_carry_reg;

endmodule

// File: tb/tb_nibble_alu_seq.sv
// tb_nibble_alu_seq
//   Self-checking bench: directed cases plus 256 random requests compared
//   against a word-level arithmetic reference model.
module tb_nibble_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic [15:0] in_a = 16'h0;
  logic [15:0] in_b = 16'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_carry;
  logic        busy;

  int checks = 0;
  int failures = 0;

  nibble_alu_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Word-level reference: {carry, data}
  function automatic logic [16:0] ref_alu(input logic [1:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    int unsigned sum;
    case (op)
      2'd0:    return {1'b0, a & b};
      2'd1:    return {1'b0, a | b};
      2'd2:    return {1'b0, a ^ b};
      default: begin
        sum = int'(a) + int'(b);
        return sum[16:0];
      end
    endcase
  endfunction

  // One full request: accept, garbage on the inputs while busy, latency
  // check, hold in DONE for 'hold' cycles, then hand off.
  task automatic run_txn(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         input int hold, input string tag);
    logic [16:0] exp;
    int lat;
    exp = ref_alu(op, a, b);
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
    step();
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    check_eq({tag, "_rdy_run"}, 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 10) begin
      in_valid = 1'b1;
      in_op = 2'($urandom_range(0, 3));
      in_a = 16'($urandom);
      in_b = 16'($urandom);
      step();
      lat++;
    end
    check_eq({tag, "_lat"}, 32'(lat), 32'd4);
    check_eq({tag, "_data"}, 32'(out_data), 32'(exp[15:0]));
    check_eq({tag, "_carry"}, 32'(out_carry), 32'(exp[16]));
    for (int i = 0; i < hold; i++) begin
      step();
      check_eq({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check_eq({tag, "_hold_data"}, {15'h0, out_carry, out_data}, 32'(exp));
      check_eq({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    check_eq({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_post_rdy"}, 32'(in_ready), 32'd1);
    check_eq({tag, "_post_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_post_data"}, {15'h0, out_carry, out_data}, 32'(exp));
    $display("txn %s op=%0d a=%04h b=%04h data=%04h carry=%0d exp=%05h lat=%0d hold=%0d",
             tag, op, a, b, out_data, out_carry, exp, lat, hold);
  endtask

  initial begin
    int seen;

    // Reset state
    rst_n = 1'b0;
    step();
    step();
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_out_carry", 32'(out_carry), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    step();

    // Directed cases
    run_txn(2'd0, 16'hF0F0, 16'hFF00, 10, "and_bp");
    run_txn(2'd3, 16'h0FFF, 16'h0001, 0, "add_chain");
    run_txn(2'd3, 16'hFFFF, 16'h0001, 2, "add_wrap");
    run_txn(2'd1, 16'h1234, 16'h8001, 1, "or");

    // Reset landing on the 2nd RUN edge aborts the request
    in_op = 2'd3; in_a = 16'h1234; in_b = 16'h4321; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_eq("abort_in_ready", 32'(in_ready), 32'd1);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_out_valid", 32'(out_valid), 32'd0);
    check_eq("abort_out_data", 32'(out_data), 32'd0);
    check_eq("abort_out_carry", 32'(out_carry), 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) seen++;
    end
    check_eq("abort_no_valid", 32'(seen), 32'd0);
    run_txn(2'd2, 16'hAAAA, 16'hFFFF, 1, "xor_after_rst");

    // Random sweep
    for (int n = 0; n < 256; n++) begin
      run_txn(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
              int'($urandom_range(0, 3)), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
